// File: rtl/multi_cycle_adder_ctrl_if.sv
// Handshake and operand/result bundle for the limb-serial adder sequencer.
// The master side issues operations; the slave side is the sequencer.
interface multi_cycle_adder_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int LIMBS = 4
);
    localparam int N = WIDTH * LIMBS;

    logic         start;
    logic         sub;
    logic         cin;
    logic         abort;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output start, sub, cin, abort, a, b,
        input  ready, busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, cin, abort, a, b,
        output ready, busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/multi_cycle_adder_ctrl.sv
// Limb-serial N-bit add/subtract: one WIDTH-bit ripple adder is reused over
// LIMBS cycles, least-significant limb first, with the carry held in a
// register between limbs. Results stay put until the next accepted start.

// Plain WIDTH-bit ripple-carry adder; the carry walks bit by bit.
module ripple_carry_adder #(
    parameter int width = 16
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout
);
    // Carry chain evaluated LSB to MSB through a local running carry.
    always_comb begin
        logic c;
        c    = cin;
        sum  = '0;
        for (int i = 0; i < width; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module multi_cycle_adder_ctrl #(
    parameter int WIDTH = 16,
    parameter int LIMBS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multi_cycle_adder_ctrl_if.slave bus
);
    localparam int N  = WIDTH * LIMBS;
    localparam int IW = ($clog2(LIMBS) < 1) ? 1 : $clog2(LIMBS);
    localparam logic [IW-1:0] LAST_IDX = IW'(LIMBS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  sum_reg;
    logic          carry_reg;
    logic          cout_reg;
    logic          overflow_reg;
    logic          done_reg;
    logic [IW-1:0] idx_reg;

    // Limb views of the captured operands so the adder input is a simple mux.
    logic [WIDTH-1:0] a_limb [LIMBS];
    logic [WIDTH-1:0] b_limb [LIMBS];

    generate
        for (genvar gi = 0; gi < LIMBS; gi++) begin : g_limb
            assign a_limb[gi] = a_reg[gi*WIDTH +: WIDTH];
            assign b_limb[gi] = b_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic [WIDTH-1:0] limb_sum;
    logic             limb_cout;
    logic             final_overflow;

    ripple_carry_adder #(
        .width(WIDTH)
    ) u_adder (
        .a    (a_limb[idx_reg]),
        .b    (b_limb[idx_reg]),
        .cin  (carry_reg),
        .sum  (limb_sum),
        .cout (limb_cout)
    );

    // b_reg already holds ~b in subtract mode, so this covers both modes.
    // Only meaningful on the last limb, where limb_sum MSB is sum[N-1].
    assign final_overflow = (a_reg[N-1] == b_reg[N-1]) &&
                            (limb_sum[WIDTH-1] != a_reg[N-1]);

    // Sequencer: capture on accept, one limb per RUN cycle, one DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            sum_reg      <= '0;
            carry_reg    <= 1'b0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            done_reg     <= 1'b0;
            idx_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.sub ? ~bus.b : bus.b;
                        carry_reg <= bus.sub | bus.cin;
                        idx_reg   <= '0;
                        sum_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state_reg    <= IDLE;
                        sum_reg      <= '0;
                        cout_reg     <= 1'b0;
                        overflow_reg <= 1'b0;
                        idx_reg      <= '0;
                    end else begin
                        sum_reg[idx_reg*WIDTH +: WIDTH] <= limb_sum;
                        carry_reg <= limb_cout;
                        if (idx_reg == LAST_IDX) begin
                            // idx stays at the last limb rather than wrapping.
                            state_reg    <= DONE;
                            done_reg     <= 1'b1;
                            cout_reg     <= limb_cout;
                            overflow_reg <= final_overflow;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready    = (state_reg == IDLE);
    assign bus.busy     = (state_reg == RUN);
    assign bus.done     = done_reg;
    assign bus.sum      = sum_reg;
    assign bus.cout     = cout_reg;
    assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_multi_cycle_adder_ctrl.sv
// Bench for the limb-serial adder: a 16x4 instance gets directed vectors with
// literal expectations, an 8x3 instance gets a random regression. A cycle
// model computes the full-width result with plain arithmetic and predicts
// handshake timing from the cycle count since accept.
module tb_multi_cycle_adder_ctrl;
    logic clk  = 1'b0;
    logic rst0 = 1'b0;
    logic rst1 = 1'b0;

    always #5 clk = ~clk;

    multi_cycle_adder_ctrl_if #(.WIDTH(16), .LIMBS(4)) bus0 ();
    multi_cycle_adder_ctrl_if #(.WIDTH(8),  .LIMBS(3)) bus1 ();

    multi_cycle_adder_ctrl #(.WIDTH(16), .LIMBS(4)) dut0 (
        .clk(clk), .rst_n(rst0), .bus(bus0)
    );
    multi_cycle_adder_ctrl #(.WIDTH(8), .LIMBS(3)) dut1 (
        .clk(clk), .rst_n(rst1), .bus(bus1)
    );

    int total  = 0;
    int passed = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    // Model state: m_age = cycles since accept (-1 when idle).
    int          m_age   [2] = '{-1, -1};
    logic [63:0] m_sum   [2] = '{64'd0, 64'd0};
    logic [63:0] m_full  [2] = '{64'd0, 64'd0};
    logic        m_cout  [2] = '{1'b0, 1'b0};
    logic        m_ovf   [2] = '{1'b0, 1'b0};
    logic        m_fcout [2] = '{1'b0, 1'b0};
    logic        m_fovf  [2] = '{1'b0, 1'b0};

    task automatic chk(input int id, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL dut%0d %s: got %h expected %h at %0t", id, name, act, exp, $time);
    endtask

    function automatic logic [63:0] mask_bits(input int n);
        if (n >= 64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    // Reference result of the full n-bit operation from exact arithmetic.
    task automatic compute(input int n, input logic [63:0] a, input logic [63:0] b,
                           input logic s, input logic c,
                           output logic [63:0] res, output logic co, output logic ov);
        logic [64:0]        ua, ub, t;
        logic signed [65:0] sa, sb, cs, ex, lim;
        ua = {1'b0, a & mask_bits(n)};
        ub = {1'b0, b & mask_bits(n)};
        sa = {2'b00, a & mask_bits(n)};
        sb = {2'b00, b & mask_bits(n)};
        if (a[n-1]) sa = sa - (66'sd1 <<< n);
        if (b[n-1]) sb = sb - (66'sd1 <<< n);
        cs  = {65'd0, c};
        lim = 66'sd1 <<< (n - 1);
        if (s) begin
            t  = ua - ub;
            co = (ua >= ub);
            ex = sa - sb;
        end else begin
            t  = ua + ub + {64'd0, c};
            co = t[n];
            ex = sa + sb + cs;
        end
        res = t[63:0] & mask_bits(n);
        ov  = (ex >= lim) || (ex < -lim);
    endtask

    task automatic model_reset(input int id);
        m_age[id]  = -1;
        m_sum[id]  = 64'd0;
        m_cout[id] = 1'b0;
        m_ovf[id]  = 1'b0;
    endtask

    task automatic model_step(input int id, input int w, input int l,
                              input logic st, input logic s, input logic c, input logic ab,
                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic        co, ov;
        if (m_age[id] < 0) begin
            if (st) begin
                compute(w * l, a, b, s, c, r, co, ov);
                m_full[id]  = r;
                m_fcout[id] = co;
                m_fovf[id]  = ov;
                m_age[id]   = 0;
                m_sum[id]   = 64'd0;
            end
        end else if (m_age[id] < l) begin
            if (ab) begin
                model_reset(id);
            end else begin
                m_age[id]++;
                m_sum[id] = m_full[id] & mask_bits(m_age[id] * w);
                if (m_age[id] == l) begin
                    m_cout[id] = m_fcout[id];
                    m_ovf[id]  = m_fovf[id];
                end
            end
        end else begin
            m_age[id] = -1;
        end
    endtask

    task automatic check_dut(input int id, input int l, input logic rdy, input logic bsy,
                             input logic dn, input logic [63:0] sm, input logic co, input logic ov);
        chk(id, "ready", 64'(rdy), 64'(m_age[id] < 0));
        chk(id, "busy",  64'(bsy), 64'(m_age[id] >= 0 && m_age[id] < l));
        chk(id, "done",  64'(dn),  64'(m_age[id] == l));
        chk(id, "sum",   sm, m_sum[id]);
        if (m_age[id] < 0 || m_age[id] == l) begin
            chk(id, "cout",     64'(co), 64'(m_cout[id]));
            chk(id, "overflow", 64'(ov), 64'(m_ovf[id]));
        end
    endtask

    // Model advances on the same edges as the DUTs.
    always @(posedge clk or negedge rst0) begin
        if (!rst0) model_reset(0);
        else model_step(0, 16, 4, bus0.start, bus0.sub, bus0.cin, bus0.abort, bus0.a, bus0.b);
    end

    always @(posedge clk or negedge rst1) begin
        if (!rst1) model_reset(1);
        else model_step(1, 8, 3, bus1.start, bus1.sub, bus1.cin, bus1.abort,
                        64'(bus1.a), 64'(bus1.b));
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        check_dut(0, 4, bus0.ready, bus0.busy, bus0.done, bus0.sum, bus0.cout, bus0.overflow);
        check_dut(1, 3, bus1.ready, bus1.busy, bus1.done, 64'(bus1.sum), bus1.cout, bus1.overflow);
        if (bus0.done) done_cnt0++;
        if (bus1.done) done_cnt1++;
    end

    task automatic go0(input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic c, input logic ab);
        int k = 0;
        while (!bus0.ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(0, "ready_wait", 64'(bus0.ready), 64'd1);
        bus0.a     = a;
        bus0.b     = b;
        bus0.sub   = s;
        bus0.cin   = c;
        bus0.abort = ab;
        bus0.start = 1'b1;
    endtask

    // Called at the negedge where start is raised; returns at the done negedge.
    task automatic finish0(input logic hold, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        @(negedge clk);
        bus0.abort = 1'b0;
        if (!hold) begin
            bus0.start = 1'b0;
        end else begin
            bus0.a   = '1;
            bus0.b   = '1;
            bus0.sub = 1'b1;
            bus0.cin = 1'b1;
        end
        while (!bus0.done && lat < 20) begin
            if (bus0.busy) bc++;
            lat++;
            @(negedge clk);
        end
        chk(0, "done_wait", 64'(bus0.done), 64'd1);
    endtask

    task automatic report0(input string name, input logic [63:0] es, input logic ec,
                           input logic eo, input int lat, input int bc);
        chk(0, {name, "_sum"},      bus0.sum, es);
        chk(0, {name, "_cout"},     64'(bus0.cout), 64'(ec));
        chk(0, {name, "_overflow"}, 64'(bus0.overflow), 64'(eo));
        chk(0, {name, "_latency"},  64'(lat), 64'd4);
        chk(0, {name, "_busy_cycles"}, 64'(bc), 64'd4);
        $display("dut0 %s: sum=%h cout=%b overflow=%b latency=%0d busy=%0d",
                 name, bus0.sum, bus0.cout, bus0.overflow, lat, bc);
    endtask

    initial begin
        int lat, bc, base;
        logic [23:0] ra, rb;
        logic        rs, rc;

        bus0.start = 0; bus0.sub = 0; bus0.cin = 0; bus0.abort = 0; bus0.a = '0; bus0.b = '0;
        bus1.start = 0; bus1.sub = 0; bus1.cin = 0; bus1.abort = 0; bus1.a = '0; bus1.b = '0;
        repeat (3) @(negedge clk);

        // Reset state, literal.
        chk(0, "rst_ready", 64'(bus0.ready), 64'd1);
        chk(0, "rst_busy",  64'(bus0.busy), 64'd0);
        chk(0, "rst_done",  64'(bus0.done), 64'd0);
        chk(0, "rst_sum",   bus0.sum, 64'd0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        @(negedge clk);

        go0(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        finish0(1'b0, lat, bc);
        report0("carry_ripple", 64'h0, 1'b1, 1'b0, lat, bc);

        // abort together with start in IDLE: start wins.
        @(negedge clk);
        go0(64'd5, 64'd7, 1'b1, 1'b1, 1'b1);
        finish0(1'b0, lat, bc);
        report0("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, lat, bc);

        @(negedge clk);
        go0(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        finish0(1'b0, lat, bc);
        report0("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, lat, bc);

        @(negedge clk);
        go0(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 1'b0);
        finish0(1'b0, lat, bc);
        report0("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, lat, bc);

        // Abort in the second RUN cycle.
        @(negedge clk);
        go0(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus0.start = 1'b0;
        @(negedge clk);
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.abort = 1'b0;
        chk(0, "abort_ready",    64'(bus0.ready), 64'd1);
        chk(0, "abort_done",     64'(bus0.done), 64'd0);
        chk(0, "abort_sum",      bus0.sum, 64'd0);
        chk(0, "abort_cout",     64'(bus0.cout), 64'd0);
        chk(0, "abort_overflow", 64'(bus0.overflow), 64'd0);
        base = done_cnt0;
        repeat (6) @(negedge clk);
        chk(0, "abort_no_done", 64'(done_cnt0 - base), 64'd0);
        $display("dut0 abort: sum=%h ready=%b", bus0.sum, bus0.ready);

        // start held high with junk operands through RUN and DONE.
        base = done_cnt0;
        go0(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0);
        finish0(1'b1, lat, bc);
        report0("held_start_op1", 64'h2345_6789_ABCD_F001, 1'b0, 1'b0, lat, bc);
        bus0.a   = 64'd100;
        bus0.b   = 64'd23;
        bus0.sub = 1'b0;
        bus0.cin = 1'b1;
        @(negedge clk);
        chk(0, "idle_ready", 64'(bus0.ready), 64'd1);
        finish0(1'b0, lat, bc);
        report0("held_start_op2", 64'h7C, 1'b0, 1'b0, lat, bc);
        @(negedge clk);
        chk(0, "one_done_per_op", 64'(done_cnt0 - base), 64'd2);

        @(negedge clk);
        go0(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        finish0(1'b0, lat, bc);
        report0("min_plus_min", 64'h0, 1'b1, 1'b1, lat, bc);

        // Asynchronous reset in the second RUN cycle.
        @(negedge clk);
        go0(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus0.start = 1'b0;
        @(negedge clk);
        #2 rst0 = 1'b0;
        #1;
        chk(0, "arst_sum",      bus0.sum, 64'd0);
        chk(0, "arst_cout",     64'(bus0.cout), 64'd0);
        chk(0, "arst_overflow", 64'(bus0.overflow), 64'd0);
        chk(0, "arst_done",     64'(bus0.done), 64'd0);
        chk(0, "arst_busy",     64'(bus0.busy), 64'd0);
        @(negedge clk);
        rst0 = 1'b1;
        base = done_cnt0;
        @(negedge clk);
        chk(0, "arst_ready", 64'(bus0.ready), 64'd1);
        repeat (6) @(negedge clk);
        chk(0, "arst_no_done", 64'(done_cnt0 - base), 64'd0);
        $display("dut0 async_reset: sum=%h ready=%b", bus0.sum, bus0.ready);

        go0(64'd3, 64'd4, 1'b0, 1'b1, 1'b0);
        finish0(1'b0, lat, bc);
        report0("after_reset", 64'd8, 1'b0, 1'b0, lat, bc);

        // Random regression on the 8x3 instance.
        for (int i = 0; i < 1000; i++) begin
            int k;
            ra = 24'($urandom);
            rb = 24'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            k = 0;
            while (!bus1.ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk(1, "ready_wait", 64'(bus1.ready), 64'd1);
            bus1.a     = ra;
            bus1.b     = rb;
            bus1.sub   = rs;
            bus1.cin   = rc;
            bus1.start = 1'b1;
            @(negedge clk);
            bus1.start = 1'b0;
            lat = 0;
            while (!bus1.done && lat < 20) begin
                lat++;
                @(negedge clk);
            end
            chk(1, "done_wait", 64'(bus1.done), 64'd1);
            chk(1, "latency", 64'(lat), 64'd3);
            $display("dut1 op %0d: a=%h b=%h sub=%b cin=%b sum=%h cout=%b overflow=%b",
                     i, ra, rb, rs, rc, bus1.sum, bus1.cout, bus1.overflow);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, total);
        $fatal(1, "watchdog");
    end
endmodule
